led_shift_ctrl: RTL and testbench
=================================

# led_shift_ctrl

Command controller and rate scheduler for the 4-LED circular shifter. Conditions four push-buttons (synchronise, debounce, rising-edge detect) and resolves simultaneous presses by fixed priority. A mode FSM then issues load, direction and shift-enable strobes to the shifter datapath. The shifter itself only executes `load` / `shift_en` / `dir`; all sequencing lives here.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised cycles required before a button level is accepted (≥1).
- `DIV`, 2: clock cycles per shift step while shifting (≥1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `button`  in  4  raw buttons: [0] load default pattern, [1] shift right, [2] shift left, [3] pause.
- `load`  out  1  one-cycle strobe: shifter reloads its default pattern.
- `shift_en`  out  1  one-cycle strobe: shifter rotates one position.
- `dir`  out  1  0 = right, 1 = left; valid whenever `shift_en` is high.
- `mode`  out  2  FSM state: 00 IDLE, 01 RIGHT, 10 LEFT, 11 PAUSE.

## Operation
- Each button passes through a 2-flop synchroniser, then the debounce filter, then a rising-edge detector. Only new presses are commands; holding or releasing a button does nothing.
- Simultaneous new edges are resolved by priority: button[0] > button[3] > button[1] > button[2]. Lower-priority edges in the same cycle are discarded, not queued.
- FSM transitions:
  - load, from any state: IDLE. `load` pulses once. Prescaler cleared. `dir` := 0.
  - right: RIGHT. `dir` := 0.
  - left: LEFT. `dir` := 1.
  - pause: from RIGHT or LEFT goes to PAUSE, with `dir` held. From IDLE or PAUSE it is ignored.
  - right/left from PAUSE resumes in the commanded direction.
  - The same direction command while already in that state: no state change, prescaler not restarted.
  - The opposite direction command: state switches and the prescaler is cleared.
- Prescaler counts 0..DIV-1 only in RIGHT/LEFT. It is frozen in PAUSE and cleared on every entry into RIGHT/LEFT or IDLE. `shift_en` is high in the cycle where the count equals DIV-1.
- `shift_en` and `load` are never high in the same cycle. `shift_en` is never high in IDLE or PAUSE.

## Timing
- Reset values: `mode` = IDLE, `dir` = 0, `load` = 0, `shift_en` = 0, prescaler = 0, synchronisers and debounced levels = 0, edge history = 0.
- Reset mid-operation aborts everything immediately. Buttons held across reset deassertion generate no command until they are released and pressed again.
- Command latency, with the debounce macro enabled:
  - If the first rising edge sampling a button high is edge 1, `mode` / `dir` / `load` update at edge 3 + DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no command.
- Command latency, without the macro: `mode` / `dir` / `load` update at edge 3.
- If `mode` enters RIGHT/LEFT at edge E, the first `shift_en` cycle follows edge E + DIV − 1 and repeats every DIV cycles. With DIV = 1, `shift_en` is continuously high while shifting.
- All outputs are registered; no combinational path from `button` to any output.

## Configuration
- `LED_SHIFT_CTRL_DEBOUNCE_EN` defined: the debounce counter is compiled in, with latency as above.
- Undefined: the debounce counter is removed. The debounced level equals the synchroniser output, `DEBOUNCE_CYCLES` is unused, and latency is 3 edges.
- Priority, FSM and prescaler behaviour are identical in both builds.

## Structure
- Shared package `led_ctrl_pkg`:
  - `mode` encodings (MODE_IDLE, MODE_RIGHT, MODE_LEFT, MODE_PAUSE).
  - button index constants (BTN_LOAD = 0, BTN_RIGHT = 1, BTN_LEFT = 2, BTN_PAUSE = 3).
  - DIR_RIGHT / DIR_LEFT.
- Sub-module `btn_conditioner`, instantiated 4×: synchroniser, debounce counter (macro-guarded) and edge detector. Output is a one-cycle `press` pulse.
- Top level holds the priority resolver, FSM and prescaler.

## Test plan
Defaults DEBOUNCE_CYCLES = 4, DIV = 2, macro defined unless stated.
- Reset then press button[1] for 20 cycles: `mode` 00→01 at edge 7. `shift_en` pulses every 2 cycles starting 1 cycle after entry, with `dir` = 0. Release: shifting continues.
- Press button[2] while in RIGHT: `mode` = 10, `dir` = 1, prescaler restarts. Then press button[3]: `mode` = 11, `shift_en` stays 0, `dir` stays 1. Release: remains 11. Press button[1]: resumes with `mode` = 01.
- button[0] pressed together with button[1]: `mode` = 00, single `load` pulse, no `shift_en`. Same cycle with button[3] + button[1] from RIGHT: `mode` = 11.
- 3-cycle glitch on button[1]: no mode change. Same glitch with the macro undefined: `mode` = 01 at edge 3.
- Assert `rst` mid-shift with button[1] held, then deassert: all outputs 0 / `mode` 00 and no command until re-press. DIV = 1 variant: `shift_en` continuously 1 in RIGHT.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED shifter command controller.
// Mode, direction, button-index and resolved-command constants.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_PAUSE = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_PAUSE,
        CMD_RIGHT,
        CMD_LEFT
    } cmd_e;

    localparam int BTN_LOAD  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_PAUSE = 3;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: 2-flop sync, optional debounce, rising-edge press.
// Debounce counter compiled in only with LED_SHIFT_CTRL_DEBOUNCE_EN.
module btn_conditioner
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0] sync_q;
    logic [1:0] vld_q;
    logic       armed_q;
    logic       prev_q;
    logic       level;

    // Presses only count once the input has been seen low after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & ~sync_q[1]);
            prev_q  <= level;
        end
    end

`ifdef LED_SHIFT_CTRL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    logic unused_db;
    assign unused_db = |DEBOUNCE_CYCLES;
    assign level     = sync_q[1];
`endif

    assign press_o = level & ~prev_q & armed_q;

endmodule

// File: rtl/led_shift_ctrl.sv
// Command controller and rate scheduler for the 4-LED shifter.
// Define LED_SHIFT_CTRL_DEBOUNCE_EN to enable button debouncing.
module led_shift_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DIV             = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button,
    output logic       load,
    output logic       shift_en,
    output logic       dir,
    output logic [1:0] mode
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic DIV1 = (DIV == 1);

    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (button[i]),
            .press_o(press[i])
        );
    end

    cmd_e cmd;

    always_comb begin
        cmd = CMD_NONE;
        if (press[BTN_LOAD]) begin
            cmd = CMD_LOAD;
        end else if (press[BTN_PAUSE]) begin
            cmd = CMD_PAUSE;
        end else if (press[BTN_RIGHT]) begin
            cmd = CMD_RIGHT;
        end else if (press[BTN_LEFT]) begin
            cmd = CMD_LEFT;
        end
    end

    mode_e         mode_q;
    logic          dir_q;
    logic          load_q;
    logic          shift_q;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          shift_d;
    logic          shifting;

    assign shifting = (mode_q == MODE_RIGHT) || (mode_q == MODE_LEFT);

    always_comb begin
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        shift_d = (cnt_d == LAST);
    end

    // Commands override the free-running prescaler step below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            dir_q   <= DIR_RIGHT;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            if (shifting) begin
                cnt_q   <= cnt_d;
                shift_q <= shift_d;
            end
            unique case (cmd)
                CMD_LOAD: begin
                    mode_q  <= MODE_IDLE;
                    dir_q   <= DIR_RIGHT;
                    load_q  <= 1'b1;
                    cnt_q   <= '0;
                    shift_q <= 1'b0;
                end
                CMD_RIGHT: begin
                    if (mode_q != MODE_RIGHT) begin
                        mode_q  <= MODE_RIGHT;
                        dir_q   <= DIR_RIGHT;
                        cnt_q   <= '0;
                        shift_q <= DIV1;
                    end
                end
                CMD_LEFT: begin
                    if (mode_q != MODE_LEFT) begin
                        mode_q  <= MODE_LEFT;
                        dir_q   <= DIR_LEFT;
                        cnt_q   <= '0;
                        shift_q <= DIV1;
                    end
                end
                CMD_PAUSE: begin
                    if (shifting) begin
                        mode_q  <= MODE_PAUSE;
                        cnt_q   <= cnt_q;
                        shift_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign load     = load_q;
    assign shift_en = shift_q;
    assign dir      = dir_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed self-checking bench for led_shift_ctrl (DIV=2 and DIV=1).
module tb_led_shift_ctrl;

    localparam int DB = 4;
`ifdef LED_SHIFT_CTRL_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
    localparam logic [1:0] GLITCH_MODE = 2'b00;
`else
    localparam int LAT = 3;
    localparam logic [1:0] GLITCH_MODE = 2'b01;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button = 4'b0000;
    logic       load, shift_en, dir;
    logic [1:0] mode;
    logic       load1, shift_en1, dir1;
    logic [1:0] mode1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    led_shift_ctrl #(.DEBOUNCE_CYCLES(DB), .DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .load    (load),
        .shift_en(shift_en),
        .dir     (dir),
        .mode    (mode)
    );

    led_shift_ctrl #(.DEBOUNCE_CYCLES(DB), .DIV(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .load    (load1),
        .shift_en(shift_en1),
        .dir     (dir1),
        .mode    (mode1)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        step(2);
        chk("rst_mode", 8'(mode), 8'h0);
        chk("rst_dir", 8'(dir), 8'h0);
        chk("rst_load", 8'(load), 8'h0);
        chk("rst_shift", 8'(shift_en), 8'h0);
        rst = 1'b0;
        step(5);

        // right press: entry at edge LAT, shift every 2 cycles
        button = 4'b0010;
        step(LAT - 1);
        chk("right_early", 8'(mode), 8'h0);
        step(1);
        chk("right_mode", 8'(mode), 8'h1);
        chk("right_dir", 8'(dir), 8'h0);
        chk("right_sh_e0", 8'(shift_en), 8'h0);
        chk("div1_sh_e0", 8'(shift_en1), 8'h1);
        step(1);
        chk("right_sh_e1", 8'(shift_en), 8'h1);
        step(1);
        chk("right_sh_e2", 8'(shift_en), 8'h0);
        step(1);
        chk("right_sh_e3", 8'(shift_en), 8'h1);
        step(10);
        chk("hold_mode", 8'(mode), 8'h1);
        chk("hold_sh", 8'(shift_en), 8'h1);
        button = 4'b0000;
        step(10);
        chk("rel_mode", 8'(mode), 8'h1);
        chk("rel_sh_odd", 8'(shift_en), 8'h1);
        step(1);
        chk("rel_sh_even", 8'(shift_en), 8'h0);

        // left while right: prescaler restarts
        button = 4'b0100;
        step(LAT);
        chk("left_mode", 8'(mode), 8'h2);
        chk("left_dir", 8'(dir), 8'h1);
        chk("left_restart", 8'(shift_en), 8'h0);
        step(1);
        chk("left_sh_e1", 8'(shift_en), 8'h1);
        chk("left_sh_dir", 8'(dir), 8'h1);
        button = 4'b0000;
        step(LAT + 2);

        // pause from left
        button = 4'b1000;
        step(LAT);
        chk("pause_mode", 8'(mode), 8'h3);
        chk("pause_sh", 8'(shift_en), 8'h0);
        chk("pause_dir", 8'(dir), 8'h1);
        step(3);
        chk("pause_sh2", 8'(shift_en), 8'h0);
        chk("pause_sh1_div1", 8'(shift_en1), 8'h0);
        button = 4'b0000;
        step(LAT + 3);
        chk("pause_rel", 8'(mode), 8'h3);
        chk("pause_rel_dir", 8'(dir), 8'h1);

        // resume right from pause
        button = 4'b0010;
        step(LAT);
        chk("resume_mode", 8'(mode), 8'h1);
        chk("resume_dir", 8'(dir), 8'h0);
        chk("resume_sh0", 8'(shift_en), 8'h0);
        step(1);
        chk("resume_sh1", 8'(shift_en), 8'h1);
        button = 4'b0000;
        step(LAT + 2);

        // load + right together: load wins
        button = 4'b0011;
        step(LAT);
        chk("load_mode", 8'(mode), 8'h0);
        chk("load_pulse", 8'(load), 8'h1);
        chk("load_sh", 8'(shift_en), 8'h0);
        chk("load_dir", 8'(dir), 8'h0);
        step(1);
        chk("load_once", 8'(load), 8'h0);
        chk("load_idle_sh", 8'(shift_en), 8'h0);
        chk("load_idle", 8'(mode), 8'h0);
        button = 4'b0000;
        step(LAT + 2);

        // pause + right from RIGHT: pause wins
        button = 4'b0010;
        step(LAT);
        chk("pr_pre", 8'(mode), 8'h1);
        button = 4'b0000;
        step(LAT + 2);
        button = 4'b1010;
        step(LAT);
        chk("pr_mode", 8'(mode), 8'h3);
        button = 4'b0000;
        step(LAT + 2);

        // back to idle, then 3-cycle glitch on right
        button = 4'b0001;
        step(LAT);
        chk("idle_again", 8'(mode), 8'h0);
        button = 4'b0000;
        step(LAT + 2);
        button = 4'b0010;
        step(3);
        button = 4'b0000;
        step(LAT + 4);
        chk("glitch_mode", 8'(mode), 8'(GLITCH_MODE));

        // reset mid-shift with right held
        button = 4'b0010;
        step(LAT + 3);
        chk("prerst_mode", 8'(mode), 8'h1);
        rst = 1'b1;
        #1;
        chk("arst_mode", 8'(mode), 8'h0);
        step(2);
        chk("rst2_dir", 8'(dir), 8'h0);
        chk("rst2_sh", 8'(shift_en), 8'h0);
        chk("rst2_load", 8'(load), 8'h0);
        rst = 1'b0;
        step(LAT + 6);
        chk("held_nocmd", 8'(mode), 8'h0);
        chk("held_nosh", 8'(shift_en), 8'h0);
        button = 4'b0000;
        step(LAT + 4);
        chk("rel_nocmd", 8'(mode), 8'h0);
        button = 4'b0010;
        step(LAT);
        chk("repress_mode", 8'(mode), 8'h1);
        step(1);
        chk("div1_cont_a", 8'(shift_en1), 8'h1);
        chk("div2_a", 8'(shift_en), 8'h1);
        step(1);
        chk("div1_cont_b", 8'(shift_en1), 8'h1);
        chk("div2_b", 8'(shift_en), 8'h0);
        button = 4'b0000;
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
